// File: rtl/md_sequencer.sv
// md_sequencer
//   Sequences multi-cycle multiply/divide operations for the E stage. On a
//   start it pulses dp_go for one cycle with the latched operands, holds busy
//   for the configured latency, then commits the external datapath results
//   into the architectural HI/LO registers. Also handles mthi/mtlo writes and
//   generates the F/D stall for instructions that touch HI/LO.
//
//   Ports
//     clk, reset           clock, synchronous active-high reset
//     op_valid, op         E-stage MD-class op and its code
//     rs_val, rt_val       forwarded operands
//     flush                cancel the same-cycle E-stage op
//     d_uses_hilo          D-stage instruction reads or writes HI/LO
//     dp_hi, dp_lo         results from the external MD datapath
//     dp_go, dp_kind       launch pulse and launched op kind
//     dp_a, dp_b           operands latched at launch
//     busy, stall          op in flight / freeze F and D
//     hi, lo               architectural HI/LO
//
//   state | meaning
//   IDLE  | no operation in flight; accepts starts and mthi/mtlo
//   RUN   | waiting for datapath latency to expire; commits when counter is 0
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        d_uses_hilo,
    input  logic [31:0] dp_hi,
    input  logic [31:0] dp_lo,
    output logic        dp_go,
    output logic [1:0]  dp_kind,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dp_go_q, dp_go_d;
    logic [1:0]    kind_q, kind_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          divz_q, divz_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic is_md, is_div, accept, start, commit;

    assign is_md  = (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
    assign is_div = (op == 4'd3) || (op == 4'd4);
    // Any E-stage op is only honoured when idle and not flushed.
    assign accept = op_valid && !flush && (state_q == S_IDLE);
    assign start  = accept && is_md;
    assign commit = (state_q == S_RUN) && (cnt_q == '0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start)  state_d = S_RUN;
            S_RUN:  if (commit) state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q == S_RUN);
        stall = d_uses_hilo && ((state_q == S_RUN) || start);
    end

    // Datapath next-state
    always_comb begin
        cnt_d   = cnt_q;
        dp_go_d = start;
        kind_d  = kind_q;
        a_d     = a_q;
        b_d     = b_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (start) begin
            cnt_d  = is_div ? DIV_LOAD : MULT_LOAD;
            // ops 1..4 map onto kinds 0..3 by dropping one from the low bits
            kind_d = op[1:0] - 2'd1;
            a_d    = rs_val;
            b_d    = rt_val;
            divz_d = is_div && (rt_val == 32'd0);
        end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Commit wins over mthi/mtlo; the two cannot coincide since accept
        // requires IDLE, but the ordering keeps that explicit.
        if (commit) begin
            if (!divz_q) begin
                hi_d = dp_hi;
                lo_d = dp_lo;
            end
        end else if (accept && (op == 4'd5)) begin
            hi_d = rs_val;
        end else if (accept && (op == 4'd6)) begin
            lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            dp_go_q <= 1'b0;
            kind_q  <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            divz_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            dp_go_q <= dp_go_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign dp_go   = dp_go_q;
    assign dp_kind = kind_q;
    assign dp_a    = a_q;
    assign dp_b    = b_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule
